bcd_mod_counter: RTL and testbench



---
 rtl/bcd_mod_counter.sv | 107 ++++++++++
 tb/tb_bcd_mod_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter over BASE..BASE+MOD-1 with validated load and a registered wrap-carry pulse.
// Latency 1 cycle from in/set_en to outputs; no backpressure. Optional down-counting via BCD_CNT_DOWN_EN.
module bcd_mod_counter #(
    parameter int MOD  = 24,
    parameter int BASE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic       set_en,
    input  logic [3:0] set_num1,
    input  logic [3:0] set_num2,
`ifdef BCD_CNT_DOWN_EN
    input  logic       dir,
`endif
    output logic [3:0] out_q1,
    output logic [3:0] out_q2,
    output logic       carry,
    output logic       load_err
);

    localparam int         TOP    = BASE + MOD - 1;
    localparam logic [3:0] BASE_T = 4'(BASE / 10);
    localparam logic [3:0] BASE_O = 4'(BASE % 10);
    localparam logic [3:0] TOP_T  = 4'(TOP / 10);
    localparam logic [3:0] TOP_O  = 4'(TOP % 10);
    localparam logic [7:0] BASE_V = 8'(BASE);
    localparam logic [7:0] TOP_V  = 8'(TOP);

    logic [3:0] r_q1;
    logic [3:0] r_q2;
    logic       r_carry;
    logic       r_load_err;

    logic [7:0] w_ld_val;
    logic       w_ld_ok;
    logic       w_at_top;
    logic       w_at_base;
    logic       w_down;

`ifdef BCD_CNT_DOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    // Digit range is checked first so an invalid digit can never alias into range.
    assign w_ld_val  = {4'd0, set_num1} * 8'd10 + {4'd0, set_num2};
    assign w_ld_ok   = (set_num1 <= 4'd9) && (set_num2 <= 4'd9) &&
                       (w_ld_val >= BASE_V) && (w_ld_val <= TOP_V);
    assign w_at_top  = (r_q1 == TOP_T)  && (r_q2 == TOP_O);
    assign w_at_base = (r_q1 == BASE_T) && (r_q2 == BASE_O);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1       <= BASE_T;
            r_q2       <= BASE_O;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else if (set_en) begin
            r_carry <= 1'b0;
            if (w_ld_ok) begin
                r_q1       <= set_num1;
                r_q2       <= set_num2;
                r_load_err <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
            end
        end else if (in) begin
            if (w_down) begin
                if (w_at_base) begin
                    r_q1    <= TOP_T;
                    r_q2    <= TOP_O;
                    r_carry <= 1'b1;
                end else if (r_q2 == 4'd0) begin
                    r_q2    <= 4'd9;
                    r_q1    <= r_q1 - 4'd1;
                    r_carry <= 1'b0;
                end else begin
                    r_q2    <= r_q2 - 4'd1;
                    r_carry <= 1'b0;
                end
            end else begin
                if (w_at_top) begin
                    r_q1    <= BASE_T;
                    r_q2    <= BASE_O;
                    r_carry <= 1'b1;
                end else if (r_q2 == 4'd9) begin
                    r_q2    <= 4'd0;
                    r_q1    <= r_q1 + 4'd1;
                    r_carry <= 1'b0;
                end else begin
                    r_q2    <= r_q2 + 4'd1;
                    r_carry <= 1'b0;
                end
            end
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign out_q1   = r_q1;
    assign out_q2   = r_q2;
    assign carry    = r_carry;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: three instances (00..23, 01..12, 00..59).
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    logic rst;
    logic in24, en24, in12, en12, in60, en60;
    logic [3:0] a24, b24, a12, b12, a60, b60;
    logic dir24, dir12, dir60;
    logic [3:0] q1_24, q2_24, q1_12, q2_12, q1_60, q2_60;
    logic c24, e24, c12, e12, c60, e60;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_mod_counter #(.MOD(24), .BASE(0)) u24 (
        .clk(clk), .rst(rst), .in(in24), .set_en(en24), .set_num1(a24), .set_num2(b24),
`ifdef BCD_CNT_DOWN_EN
        .dir(dir24),
`endif
        .out_q1(q1_24), .out_q2(q2_24), .carry(c24), .load_err(e24));

    bcd_mod_counter #(.MOD(12), .BASE(1)) u12 (
        .clk(clk), .rst(rst), .in(in12), .set_en(en12), .set_num1(a12), .set_num2(b12),
`ifdef BCD_CNT_DOWN_EN
        .dir(dir12),
`endif
        .out_q1(q1_12), .out_q2(q2_12), .carry(c12), .load_err(e12));

    bcd_mod_counter #(.MOD(60), .BASE(0)) u60 (
        .clk(clk), .rst(rst), .in(in60), .set_en(en60), .set_num1(a60), .set_num2(b60),
`ifdef BCD_CNT_DOWN_EN
        .dir(dir60),
`endif
        .out_q1(q1_60), .out_q2(q2_60), .carry(c60), .load_err(e60));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_v;
        rst = 1'b1;
        in24 = 0; en24 = 0; a24 = 0; b24 = 0; dir24 = 0;
        in12 = 0; en12 = 0; a12 = 0; b12 = 0; dir12 = 0;
        in60 = 0; en60 = 0; a60 = 0; b60 = 0; dir60 = 0;
        tick;
        chk("rst24_val", {q1_24, q2_24}, 8'h00);
        chk("rst24_flags", {6'd0, c24, e24}, 8'h00);
        chk("rst12_val", {q1_12, q2_12}, 8'h01);
        chk("rst60_val", {q1_60, q2_60}, 8'h00);
        rst = 1'b0;

        // Full cycle of the hour counter; carry only after 23 -> 00
        in24 = 1;
        for (int i = 1; i <= 24; i++) begin
            tick;
            exp_v = 8'(((i % 24) / 10) * 16 + (i % 24) % 10);
            chk($sformatf("up24_val_%0d", i), {q1_24, q2_24}, exp_v);
            chk($sformatf("up24_carry_%0d", i), {7'd0, c24}, (i == 24) ? 8'h01 : 8'h00);
        end
        in24 = 0;
        tick;
        chk("idle24_val", {q1_24, q2_24}, 8'h00);
        chk("idle24_carry", {7'd0, c24}, 8'h00);

        // Load beats tick
        en24 = 1; a24 = 4'd2; b24 = 4'd2;
        tick;
        chk("ld24_22", {q1_24, q2_24}, 8'h22);
        a24 = 4'd0; b24 = 4'd7; in24 = 1;
        tick;
        chk("ld_over_tick", {q1_24, q2_24}, 8'h07);
        chk("ld_over_tick_c", {7'd0, c24}, 8'h00);
        in24 = 0;

        // Rejected load, sticky error across counting, then reset mid-count
        a24 = 4'd9; b24 = 4'd9;
        tick;
        chk("rej24_val", {q1_24, q2_24}, 8'h07);
        chk("rej24_err", {7'd0, e24}, 8'h01);
        en24 = 0; in24 = 1;
        repeat (10) tick;
        chk("cnt24_17", {q1_24, q2_24}, 8'h17);
        chk("err24_sticky", {7'd0, e24}, 8'h01);
        rst = 1;
        tick;
        rst = 0; in24 = 0;
        chk("rst_mid_val", {q1_24, q2_24}, 8'h00);
        chk("rst_mid_flags", {6'd0, c24, e24}, 8'h00);

        // 12h counter 01..12
        en12 = 1; a12 = 4'd1; b12 = 4'd2;
        tick;
        chk("ld12_12", {q1_12, q2_12}, 8'h12);
        en12 = 0; in12 = 1;
        tick;
        chk("wrap12_val", {q1_12, q2_12}, 8'h01);
        chk("wrap12_carry", {7'd0, c12}, 8'h01);
        in12 = 0;
        tick;
        chk("carry12_pulse", {7'd0, c12}, 8'h00);
        en12 = 1; a12 = 4'd0; b12 = 4'd0;
        tick;
        chk("rej12_00_val", {q1_12, q2_12}, 8'h01);
        chk("rej12_00_err", {7'd0, e12}, 8'h01);
        a12 = 4'd1; b12 = 4'd3;
        tick;
        chk("rej12_13_val", {q1_12, q2_12}, 8'h01);
        chk("rej12_13_err", {7'd0, e12}, 8'h01);
        a12 = 4'd0; b12 = 4'd5;
        tick;
        chk("ld12_05", {q1_12, q2_12}, 8'h05);
        chk("ld12_05_err", {7'd0, e12}, 8'h00);
        en12 = 0;

        // Seconds counter: invalid BCD then valid load, 59 wrap
        en60 = 1; a60 = 4'd5; b60 = 4'hA;
        tick;
        chk("rej60_val", {q1_60, q2_60}, 8'h00);
        chk("rej60_err", {7'd0, e60}, 8'h01);
        a60 = 4'd4; b60 = 4'd5;
        tick;
        chk("ld60_45", {q1_60, q2_60}, 8'h45);
        chk("ld60_err", {7'd0, e60}, 8'h00);
        a60 = 4'd5; b60 = 4'd9;
        tick;
        en60 = 0; in60 = 1;
        tick;
        chk("wrap60_val", {q1_60, q2_60}, 8'h00);
        chk("wrap60_carry", {7'd0, c60}, 8'h01);
        tick;
        chk("up60_01", {q1_60, q2_60}, 8'h01);
        chk("up60_carry", {7'd0, c60}, 8'h00);
        in60 = 0;

`ifdef BCD_CNT_DOWN_EN
        dir60 = 1; en60 = 1; a60 = 4'd0; b60 = 4'd1;
        tick;
        en60 = 0; in60 = 1;
        tick;
        chk("dn60_00", {q1_60, q2_60}, 8'h00);
        chk("dn60_00_c", {7'd0, c60}, 8'h00);
        tick;
        chk("dn60_59", {q1_60, q2_60}, 8'h59);
        chk("dn60_borrow", {7'd0, c60}, 8'h01);
        in60 = 0; en60 = 1; a60 = 4'd1; b60 = 4'd0;
        tick;
        en60 = 0; in60 = 1;
        tick;
        chk("dn60_09", {q1_60, q2_60}, 8'h09);
        chk("dn60_09_c", {7'd0, c60}, 8'h00);
        in60 = 0; dir60 = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
